// File: rtl/profile_timer_pkg.sv
// Shared opcode encoding, command field layout and error word for the profiling timer.
package profile_timer_pkg;
  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_START    = 4'd1,
    OP_STOP     = 4'd2,
    OP_READ_ACC = 4'd3,
    OP_READ_NOW = 4'd4,
    OP_CLEAR    = 4'd5
  } op_e;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 3;
  localparam int CH_LSB = 8;
  localparam int CH_MSB = 15;

  // Sliced down to WIDTH by users; covers any WIDTH up to 256.
  localparam logic [255:0] ERR_WORD = '1;
endpackage

// File: rtl/profile_channel.sv
// One stopwatch channel: running flag, start stamp and accumulator.
module profile_channel
  import profile_timer_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int SATURATE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [WIDTH-1:0] now,
  output logic             running,
  output logic [WIDTH-1:0] stamp,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] delta
);
  logic [WIDTH:0] sum;

  // Modular subtraction gives the right interval across a counter wrap.
  assign delta = now - stamp;
  assign sum   = {1'b0, acc} + {1'b0, delta};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      stamp   <= '0;
      acc     <= '0;
    end else if (clear) begin
      running <= 1'b0;
      acc     <= '0;
    end else if (start && !running) begin
      running <= 1'b1;
      stamp   <= now;
    end else if (stop && running) begin
      running <= 1'b0;
      acc     <= ((SATURATE != 0) && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/profile_timer_mc.sv
// Multi-channel profiling stopwatch: free-running timestamp, command decode, single-entry result register.
module profile_timer_mc
  import profile_timer_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ivalid,
  output logic              iready,
  input  logic [WIDTH-1:0]  command,
  output logic              ovalid,
  input  logic              oready,
  output logic [WIDTH-1:0]  result,
  output logic [NUM_CH-1:0] running
);
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [WIDTH-1:0] ERR = ERR_WORD[WIDTH-1:0];

  logic [WIDTH-1:0]             now, nxt;
  logic [15:0]                  cw;
  op_e                          op;
  logic [7:0]                   ch;
  logic [SW-1:0]                sel;
  logic                         in_range, accept, hit;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_stamp, ch_acc, ch_delta;

  // Narrow command words simply lack the channel field and address channel 0.
  assign cw       = 16'(command);
  assign op       = op_e'(cw[OP_MSB:OP_LSB]);
  assign ch       = cw[CH_MSB:CH_LSB];
  assign sel      = ch[SW-1:0];
  assign in_range = 32'(ch) < NUM_CH;
  assign iready   = ~reset & (~ovalid | oready);
  assign accept   = ivalid & iready;
  assign hit      = accept & in_range;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic me;
    assign me = hit && (sel == SW'(i));
    profile_channel #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_ch (
      .clock   (clock),
      .reset   (reset),
      .start   (me && op == OP_START),
      .stop    (me && op == OP_STOP),
      .clear   (me && op == OP_CLEAR),
      .now     (now),
      .running (running[i]),
      .stamp   (ch_stamp[i]),
      .acc     (ch_acc[i]),
      .delta   (ch_delta[i])
    );
  end

  always_comb begin
    nxt = now;
    case (op)
      OP_START:    nxt = !in_range ? ERR : (running[sel] ? ch_stamp[sel] : now);
      OP_STOP:     nxt = !in_range ? ERR : (running[sel] ? ch_delta[sel] : '0);
      OP_READ_ACC,
      OP_CLEAR:    nxt = !in_range ? ERR : ch_acc[sel];
      default:     nxt = now;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) now <= '0;
    else       now <= now + WIDTH'(1);
  end

  // Result holds until consumed; a new accept overwrites it in the same edge it drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovalid <= 1'b0;
      result <= '0;
    end else if (accept) begin
      ovalid <= 1'b1;
      result <= nxt;
    end else if (oready) begin
      ovalid <= 1'b0;
    end
  end
endmodule
